// File: rtl/rq_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : rq_scheduler
// Brief    : Elevator request scheduler. Latches hall/car buttons, runs an
//            IDLE/UP/DOWN/DWELL controller against a one-hot floor position
//            and clears served requests when the door opens.
// Options  : RQ_CANCEL_EN - re-pressing a lit car button cancels it.
// Revision : 1.0 - initial release
// ============================================================================
module rq_scheduler #(
    parameter int FLOORS = 4,
    parameter int DWELL  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FLOORS-1:0] up_req,
    input  logic [FLOORS-1:0] down_req,
    input  logic [FLOORS-1:0] in_req,
    input  logic [FLOORS-1:0] position,
    output logic [FLOORS-1:0] up_reg,
    output logic [FLOORS-1:0] down_reg,
    output logic [FLOORS-1:0] in_reg,
    output logic [FLOORS-1:0] all_reg,
    output logic [1:0]        ud_mode,
    output logic              door_open
);

    localparam int                CNT_W     = $clog2(DWELL + 1);
    localparam logic [CNT_W-1:0]  c_CNT_LD  = CNT_W'(DWELL - 1);
    localparam logic [FLOORS-1:0] c_ONE     = FLOORS'(1);
    // Top floor has no up button, bottom floor has no down button
    localparam logic [FLOORS-1:0] c_UP_MASK = {1'b0, {(FLOORS-1){1'b1}}};
    localparam logic [FLOORS-1:0] c_DN_MASK = {{(FLOORS-1){1'b1}}, 1'b0};
    // Retained direction shares the ud_mode encoding
    localparam logic [1:0]        c_DIR_NONE = 2'b00;
    localparam logic [1:0]        c_DIR_UP   = 2'b01;
    localparam logic [1:0]        c_DIR_DN   = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_UP    = 2'd1,
        S_DOWN  = 2'd2,
        S_DWELL = 2'd3
    } state_t;

    state_t            r_state;
    logic [1:0]        r_dir;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_ud_mode;
    logic              r_door;
    logic [FLOORS-1:0] r_up;
    logic [FLOORS-1:0] r_dn;
    logic [FLOORS-1:0] r_in;

    state_t            w_nxt_state;
    logic [1:0]        w_nxt_dir;
    logic              w_enter_dwell;
    logic              w_pos_valid;
    logic [FLOORS-1:0] w_below_mask;
    logic [FLOORS-1:0] w_above_mask;
    logic [FLOORS-1:0] w_all;
    logic              w_any_above;
    logic              w_any_below;
    logic              w_at_up;
    logic              w_at_dn;
    logic              w_at_in;
    logic              w_up_stop_fwd;
    logic              w_up_stop_rev;
    logic              w_dn_stop_fwd;
    logic              w_dn_stop_rev;
    logic [FLOORS-1:0] w_clr_up;
    logic [FLOORS-1:0] w_clr_dn;
    logic [FLOORS-1:0] w_clr_in;
    logic [FLOORS-1:0] w_blk_up;
    logic [FLOORS-1:0] w_blk_dn;
    logic [FLOORS-1:0] w_blk_in;
    logic [FLOORS-1:0] w_cancel;

    // Position decode: a valid position has exactly one bit set
    assign w_pos_valid  = (position != '0) && ((position & (position - c_ONE)) == '0);
    assign w_below_mask = position - c_ONE;
    assign w_above_mask = ~(w_below_mask | position);

    assign w_all        = r_up | r_dn | r_in;
    assign w_any_above  = |(w_all & w_above_mask);
    assign w_any_below  = |(w_all & w_below_mask);
    assign w_at_up      = |(r_up & position);
    assign w_at_dn      = |(r_dn & position);
    assign w_at_in      = |(r_in & position);

    // Forward stop serves riders going our way; reverse stop only when the
    // run is exhausted and someone here wants the opposite direction.
    assign w_up_stop_fwd = w_at_up | w_at_in;
    assign w_up_stop_rev = !w_any_above && w_at_dn;
    assign w_dn_stop_fwd = w_at_dn | w_at_in;
    assign w_dn_stop_rev = !w_any_below && w_at_up;

    // Next-state and retained-direction decision
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_dir   = r_dir;
        if (w_pos_valid) begin
            case (r_state)
                S_IDLE: begin
                    if (w_at_up || w_at_dn || w_at_in) begin
                        w_nxt_state = S_DWELL;
                        w_nxt_dir   = c_DIR_NONE;
                    end else if (w_any_above) begin
                        w_nxt_state = S_UP;
                    end else if (w_any_below) begin
                        w_nxt_state = S_DOWN;
                    end
                end
                S_UP: begin
                    if (w_up_stop_fwd) begin
                        w_nxt_state = S_DWELL;
                        w_nxt_dir   = c_DIR_UP;
                    end else if (w_up_stop_rev) begin
                        w_nxt_state = S_DWELL;
                        w_nxt_dir   = c_DIR_DN;
                    end else if (!w_any_above) begin
                        w_nxt_state = w_any_below ? S_DOWN : S_IDLE;
                    end
                end
                S_DOWN: begin
                    if (w_dn_stop_fwd) begin
                        w_nxt_state = S_DWELL;
                        w_nxt_dir   = c_DIR_DN;
                    end else if (w_dn_stop_rev) begin
                        w_nxt_state = S_DWELL;
                        w_nxt_dir   = c_DIR_UP;
                    end else if (!w_any_below) begin
                        w_nxt_state = w_any_above ? S_UP : S_IDLE;
                    end
                end
                default: begin
                    // Door closes: keep going the retained way if possible
                    if (r_cnt == '0) begin
                        if (r_dir == c_DIR_DN) begin
                            w_nxt_state = w_any_below ? S_DOWN :
                                          (w_any_above ? S_UP : S_IDLE);
                        end else begin
                            w_nxt_state = w_any_above ? S_UP :
                                          (w_any_below ? S_DOWN : S_IDLE);
                        end
                    end
                end
            endcase
        end
    end

    assign w_enter_dwell = (r_state != S_DWELL) && (w_nxt_state == S_DWELL);

    // Clear-on-arrival and in-dwell press suppression at the current floor
    always_comb begin
        w_clr_up = '0;
        w_clr_dn = '0;
        w_clr_in = '0;
        w_blk_up = '0;
        w_blk_dn = '0;
        w_blk_in = '0;
        if (w_enter_dwell) begin
            w_clr_in = position;
            if (w_nxt_dir != c_DIR_DN) w_clr_up = position;
            if (w_nxt_dir != c_DIR_UP) w_clr_dn = position;
        end
        if (w_pos_valid && (r_state == S_DWELL)) begin
            w_blk_in = position;
            if (r_dir != c_DIR_DN) w_blk_up = position;
            if (r_dir != c_DIR_UP) w_blk_dn = position;
        end
    end

`ifdef RQ_CANCEL_EN
    logic [FLOORS-1:0] r_in_req_q;
    logic [FLOORS-1:0] w_cancel_keep;

    // Previous car-button sample for press (rising-edge) detection
    always_ff @(posedge clk) begin
        if (!rst_n) r_in_req_q <= '0;
        else        r_in_req_q <= in_req;
    end

    assign w_cancel_keep = (r_state == S_DWELL) ? position : '0;
    assign w_cancel      = in_req & ~r_in_req_q & r_in & ~w_cancel_keep;
`else
    assign w_cancel      = '0;
`endif

    // Request registers: set-only latch, clear has priority
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_up <= '0;
            r_dn <= '0;
            r_in <= '0;
        end else begin
            r_up <= (r_up | (up_req   & c_UP_MASK & ~w_blk_up)) & ~w_clr_up;
            r_dn <= (r_dn | (down_req & c_DN_MASK & ~w_blk_dn)) & ~w_clr_dn;
            r_in <= (r_in | (in_req   & ~w_blk_in)) & ~(w_clr_in | w_cancel);
        end
    end

    // Controller state, dwell counter and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_dir     <= c_DIR_NONE;
            r_cnt     <= '0;
            r_ud_mode <= 2'b00;
            r_door    <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_dir   <= w_nxt_dir;
            if (w_enter_dwell) begin
                r_cnt <= c_CNT_LD;
            end else if (w_pos_valid && (r_state == S_DWELL) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            case (w_nxt_state)
                S_UP:    r_ud_mode <= 2'b01;
                S_DOWN:  r_ud_mode <= 2'b10;
                default: r_ud_mode <= 2'b00;
            endcase
            r_door <= (w_nxt_state == S_DWELL);
        end
    end

    assign up_reg    = r_up;
    assign down_reg  = r_dn;
    assign in_reg    = r_in;
    assign all_reg   = r_up | r_dn | r_in;
    assign ud_mode   = r_ud_mode;
    assign door_open = r_door;

endmodule
`default_nettype wire

// File: tb/tb_rq_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_rq_scheduler
// Brief    : Directed self-checking bench for rq_scheduler (FLOORS=4, DWELL=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rq_scheduler;

    logic       clk;
    logic       rst_n;
    logic [3:0] up_req;
    logic [3:0] down_req;
    logic [3:0] in_req;
    logic [3:0] position;
    logic [3:0] up_reg;
    logic [3:0] down_reg;
    logic [3:0] in_reg;
    logic [3:0] all_reg;
    logic [1:0] ud_mode;
    logic       door_open;

    int checks = 0;
    int errors = 0;

    rq_scheduler #(.FLOORS(4), .DWELL(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .up_req    (up_req),
        .down_req  (down_req),
        .in_req    (in_req),
        .position  (position),
        .up_reg    (up_reg),
        .down_reg  (down_reg),
        .in_reg    (in_reg),
        .all_reg   (all_reg),
        .ud_mode   (ud_mode),
        .door_open (door_open)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs change and outputs are sampled 1ns later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] cancel_exp;
        rst_n = 1'b0; up_req = '0; down_req = '0; in_req = 4'b1111; position = 4'b0001;

        // Reset with buttons held: nothing may latch
        tick(); tick(); tick();
        rst_n = 1'b1; in_req = '0;
        chk("rst_up",   {4'd0, up_reg},   8'h00);
        chk("rst_dn",   {4'd0, down_reg}, 8'h00);
        chk("rst_in",   {4'd0, in_reg},   8'h00);
        chk("rst_mode", {6'd0, ud_mode},  8'h00);
        chk("rst_door", {7'd0, door_open}, 8'h00);

        // Car call to floor 2 from floor 0
        in_req = 4'b0100;
        tick(); in_req = '0;
        chk("a_in_latch", {4'd0, in_reg}, 8'h04);
        tick();
        chk("a_mode_up", {6'd0, ud_mode}, 8'h01);
        chk("a_all",     {4'd0, all_reg}, 8'h04);
        position = 4'b0010; tick();
        chk("a_pass1",   {6'd0, ud_mode}, 8'h01);
        position = 4'b0100; tick();
        chk("a_door",    {7'd0, door_open}, 8'h01);
        chk("a_in_clr",  {4'd0, in_reg},  8'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("a_door_hold", {7'd0, door_open}, 8'h01);
        end
        tick();
        chk("a_door_end", {7'd0, door_open}, 8'h00);
        chk("a_idle",     {6'd0, ud_mode},   8'h00);

        // Stop at floor 1 going up, then continue to floor 3
        position = 4'b0001; up_req = 4'b0010; in_req = 4'b1000;
        tick(); up_req = '0; in_req = '0;
        tick();
        chk("b_mode_up", {6'd0, ud_mode}, 8'h01);
        position = 4'b0010; tick();
        chk("b_door",    {7'd0, door_open}, 8'h01);
        chk("b_up_clr",  {4'd0, up_reg},  8'h00);
        chk("b_in_keep", {4'd0, in_reg},  8'h08);
        up_req = 4'b0010; tick(); up_req = '0;
        chk("b_up_blk",  {4'd0, up_reg},  8'h00);
        tick(); tick();
        chk("b_door_3",  {7'd0, door_open}, 8'h01);
        tick();
        chk("b_resume",  {6'd0, ud_mode}, 8'h01);
        chk("b_door_off", {7'd0, door_open}, 8'h00);
        position = 4'b1000; tick();
        chk("b_top_door", {7'd0, door_open}, 8'h01);
        tick(); tick(); tick(); tick();
        chk("b_idle", {6'd0, ud_mode}, 8'h00);
        chk("b_all0", {4'd0, all_reg}, 8'h00);

        // Down call at the top floor: pass intermediate floors
        position = 4'b0001; down_req = 4'b1000;
        tick(); down_req = '0;
        chk("c_dn_latch", {4'd0, down_reg}, 8'h08);
        tick();
        chk("c_mode_up",  {6'd0, ud_mode}, 8'h01);
        position = 4'b0010; tick();
        chk("c_pass1",    {7'd0, door_open}, 8'h00);
        position = 4'b0100; tick();
        chk("c_pass2",    {6'd0, ud_mode}, 8'h01);
        position = 4'b1000; tick();
        chk("c_door",     {7'd0, door_open}, 8'h01);
        chk("c_dn_clr",   {4'd0, down_reg}, 8'h00);
        tick(); tick(); tick(); tick();
        chk("c_idle",     {6'd0, ud_mode}, 8'h00);
        chk("c_door_off", {7'd0, door_open}, 8'h00);

        // Going down, lone up call below is a reversal stop
        up_req = 4'b0010;
        tick(); up_req = '0;
        chk("d_up_latch", {4'd0, up_reg}, 8'h02);
        tick();
        chk("d_mode_dn",  {6'd0, ud_mode}, 8'h02);
        position = 4'b0100; tick();
        chk("d_pass",     {6'd0, ud_mode}, 8'h02);
        position = 4'b0010; tick();
        chk("d_door",     {7'd0, door_open}, 8'h01);
        chk("d_up_clr",   {4'd0, up_reg}, 8'h00);
        tick(); tick(); tick(); tick();
        chk("d_idle",     {6'd0, ud_mode}, 8'h00);

        // Invalid position: buttons latch but controller holds
        position = 4'b0000; in_req = 4'b0001;
        tick(); in_req = '0;
        chk("e_latch",    {4'd0, in_reg}, 8'h01);
        tick();
        chk("e_hold",     {6'd0, ud_mode}, 8'h00);
        position = 4'b0001; tick();
        chk("e_door",     {7'd0, door_open}, 8'h01);
        chk("e_in_clr",   {4'd0, in_reg}, 8'h00);
        position = 4'b0011;
        for (int i = 0; i < 5; i++) tick();
        chk("e_cnt_hold", {7'd0, door_open}, 8'h01);
        position = 4'b0001;
        tick(); tick(); tick();
        chk("e_door_3",   {7'd0, door_open}, 8'h01);
        tick();
        chk("e_door_end", {7'd0, door_open}, 8'h00);

        // Re-press of a lit car button
`ifdef RQ_CANCEL_EN
        cancel_exp = 4'b0000;
`else
        cancel_exp = 4'b0100;
`endif
        in_req = 4'b0100;
        tick(); in_req = '0;
        chk("f_latch", {4'd0, in_reg}, 8'h04);
        tick();
        in_req = 4'b0100;
        tick(); in_req = '0;
        chk("f_repress", {4'd0, in_reg}, {4'd0, cancel_exp});

        // Reset in the middle of a dwell
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        position = 4'b0100; in_req = 4'b1101;
        tick(); in_req = '0;
        tick();
        chk("g_door",  {7'd0, door_open}, 8'h01);
        chk("g_in",    {4'd0, in_reg}, 8'h09);
        rst_n = 1'b0; in_req = 4'b1111; up_req = 4'b1111; down_req = 4'b1111;
        tick();
        chk("g_rst_in",   {4'd0, in_reg}, 8'h00);
        chk("g_rst_all",  {4'd0, all_reg}, 8'h00);
        chk("g_rst_door", {7'd0, door_open}, 8'h00);
        chk("g_rst_mode", {6'd0, ud_mode}, 8'h00);
        rst_n = 1'b1; in_req = '0; up_req = '0; down_req = '0;
        tick();
        chk("g_after",    {4'd0, all_reg}, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rq_scheduler.md
RQ_SCHEDULER -- requirements
Module: rq_scheduler

Interface
REQ-001 Parameter FLOORS, default 4, number of floors (min 2).
REQ-002 Parameter DWELL, default 8, door-open time in clk cycles (min 1).
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 up_req  input  FLOORS  hall up buttons, one bit per floor; bit FLOORS-1 ignored.
REQ-006 down_req  input  FLOORS  hall down buttons; bit 0 ignored.
REQ-007 in_req  input  FLOORS  in-car floor buttons.
REQ-008 position  input  FLOORS  one-hot current floor; bit 0 = lowest floor.
REQ-009 up_reg, down_reg, in_reg  output  FLOORS each  latched pending requests.
REQ-010 all_reg  output  FLOORS  OR of up_reg, down_reg, in_reg.
REQ-011 ud_mode  output  2  00 idle/dwell, 01 up, 10 down; 11 never driven.
REQ-012 door_open  output  1  high only in DWELL.

Function
REQ-013 SHALL latch each input button bit into its register (set-only OR) one cycle after sampling; ignored bits stay 0.
REQ-014 SHALL run FSM IDLE, UP, DOWN, DWELL; ud_mode = 01 in UP, 10 in DOWN, 00 otherwise.
REQ-015 Above(p)/below(p) SHALL be all_reg bits strictly above/below the position bit.
REQ-016 IDLE: request at position -> DWELL; else above nonzero -> UP; else below nonzero -> DOWN; else stay; the at-position check wins.
REQ-017 UP stops (-> DWELL) when up_reg or in_reg bit at position set, or no requests above and down_reg bit at position set.
REQ-018 DOWN stops when down_reg or in_reg bit at position set, or no requests below and up_reg bit at position set.
REQ-019 UP/DOWN with no stop and nothing ahead: reverse if requests behind, else IDLE.
REQ-020 On entering DWELL, SHALL clear in_reg bit at position plus the hall bit of the travel direction; direction-reversal stop clears the opposite hall bit instead; from IDLE clears all bits at position.
REQ-021 DWELL SHALL last exactly DWELL cycles (counter width clog2(DWELL+1)); hall/in bits at position pressed during DWELL are not latched if matching the retained direction.
REQ-022 DWELL exit: continue retained direction if requests ahead, else reverse if behind, else IDLE.
REQ-023 Simultaneous set and clear of the same bit in one cycle: clear wins.
REQ-024 position not one-hot (zero or multi-bit): SHALL hold state, counter and registers; buttons still latch.
REQ-025 Floor 0 and floor FLOORS-1 SHALL behave as direction limits; no wrap-around.

Reset
REQ-026 rst_n low at a clk edge SHALL clear all request registers, counter and retained direction, enter IDLE, drive ud_mode 00, door_open 0.
REQ-027 Reset mid-motion or mid-dwell SHALL discard all pending requests; inputs during reset are not latched.

Configuration
REQ-028 Macro RQ_CANCEL_EN defined: an in_req bit pressed while its in_reg bit is already set (rising edge, one-cycle registered input) SHALL clear that bit, unless it is the current floor in DWELL.
REQ-029 RQ_CANCEL_EN undefined: in_req set-only; no edge-detect register synthesised.

Verification (FLOORS=4, DWELL=4)
REQ-030 Reset, position 0001, in_req 0100 pulse -> in_reg 0100 next cycle, ud_mode 01 following cycle.
REQ-031 UP at 0010 with up_reg 0010, in_reg 1000 -> door_open 1 for exactly 4 cycles, up_reg 0000, then ud_mode 01.
REQ-032 Position 0001, only down_reg 1000 -> UP passes 0010/0100 without stop, DWELL at 1000, down_reg cleared, then IDLE.
REQ-033 DOWN at 0100, pending up_reg 0010 only -> stops at 0010 (REQ-018), clears up_reg, then IDLE.
REQ-034 rst_n low during DWELL with in_reg 1001 -> next cycle all registers 0000, IDLE, door_open 0.
REQ-035 RQ_CANCEL_EN, in_reg 0100, press in_req 0100 again -> in_reg 0000 next cycle; without macro stays 0100.
